multi_timer: RTL and testbench
==============================

// Module: multi_timer
//
// PURPOSE
//   Multi-channel programmable timer; successor to the fixed single-period timer.
//   A shared prescaler divides clk down to a TICK_HZ tick. CHANNELS independent
//   down-counters count that tick, each with a runtime period and a one-shot or
//   periodic mode. Used by the terminal core for cursor blink, bell, UART timeouts.
//
// PARAMETERS
//   CLK_HZ       27_000_000  input clock frequency
//   TICK_HZ      1_000       prescaler tick rate; ratio = CLK_HZ/TICK_HZ (floor), >= 1
//   CHANNELS     4           number of independent channels, >= 1
//   COUNT_WIDTH  16          width of period and count, in ticks
//
// PORTS
//   clk       in   1                   sole clock, rising edge
//   reset     in   1                   asynchronous, active-high
//   start     in   CHANNELS            per channel: load period and run
//   stop      in   CHANNELS            per channel: halt, keep count
//   clear     in   CHANNELS            per channel: to IDLE, count 0, done 0
//   periodic  in   CHANNELS            per channel mode: 1 = auto-reload, 0 = one-shot
//   period    in   CHANNELS*COUNT_WIDTH  flat; ch i = [i*COUNT_WIDTH +: COUNT_WIDTH]
//   tick      out  1                   prescaler pulse, for debug and chaining
//   running   out  CHANNELS            channel in RUN
//   expired   out  CHANNELS            one-cycle pulse per expiry
//   done      out  CHANNELS            sticky; set on one-shot expiry
//
// BEHAVIOUR
//   Reset (async, any time): prescaler 0; every channel IDLE, count 0;
//     tick/running/expired/done all 0 while reset is high and after release.
//   Prescaler: free-running 0..ratio-1; tick=1 for 1 cycle when it wraps.
//     ratio==1: tick high every cycle. Elaboration error if TICK_HZ > CLK_HZ or 0.
//   Channel FSM: IDLE, RUN, DONE. Command priority per cycle:
//     clear > start > stop > tick.
//   - clear (any state): -> IDLE, count 0, done 0.
//   - start (any state): period==0 -> ignored, no state change. Else -> RUN,
//     count <= period, done 0. A tick in the same cycle as start is not counted.
//   - stop: RUN -> IDLE, count held. IDLE/DONE unchanged. No resume; restart = start.
//   - tick in RUN: count > 1 -> count-1. count == 1 -> expiry:
//       expired pulses on the next cycle (registered, 1 cycle);
//       periodic=1: count <= current period (sampled at expiry), stay RUN;
//         period==0 at reload -> IDLE, no further expiries;
//       periodic=0: -> DONE, done <= 1, count 0.
//   - Expiry timing: exactly period ticks after start; with ratio R, first
//     expired pulse within period*R cycles (+1 registration cycle).
//   - periodic and period are sampled at start and at each expiry only;
//     changes mid-count take effect at the next reload.
//   - running = (state==RUN), registered; asserted the cycle after start.
//   - Channels are fully independent; commands to ch i never affect ch j.
//   Arithmetic: unsigned, COUNT_WIDTH bits; count never wraps below 0.
//
// STRUCTURE
//   Shared package: channel state enum (IDLE/RUN/DONE) typedef, and the existing
//   YES/NO/HIGH/LOW constants. Sub-module timer_prescaler (CLK_HZ, TICK_HZ ->
//   tick) instantiated once. Channels via generate loop, in this module.
//
// TESTING  (CLK_HZ=100, TICK_HZ=10 => ratio 10, CHANNELS=4, COUNT_WIDTH=8)
//   1. Release reset -> all outputs 0; tick high every 10th cycle, exactly 1 cycle.
//   2. ch0 one-shot, period=3, start -> expired[0] once after 3rd tick, then
//      done[0]=1, running[0]=0; no further pulses over 100 cycles.
//   3. ch1 periodic, period=2 -> expired[1] every 20 cycles; set period=4
//      mid-count -> current interval stays 20, following intervals 40.
//   4. Same-cycle clear+start on ch2 -> IDLE, done 0; start+stop -> RUN;
//      start with period=0 on IDLE ch2 -> stays IDLE.
//   5. Restart: start ch0 again at count 1 -> count reloads, expiry delayed
//      a full period; ch3 untouched throughout.
//   6. Assert reset mid-count (async, off clock edge) -> outputs 0 immediately;
//      after release, no stale expiry; new start times correctly.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel timer.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_DONE = 2'd2
    } ch_state_e;

    localparam logic YES  = 1'b1;
    localparam logic NO   = 1'b0;
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running clock divider producing a one-cycle registered tick every CLK_HZ/TICK_HZ cycles.
module timer_prescaler
    import multi_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 27_000_000,
    parameter int unsigned TICK_HZ = 1_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned RATIO_RAW = (TICK_HZ == 0) ? 1 : CLK_HZ / TICK_HZ;
    localparam int unsigned RATIO     = (RATIO_RAW == 0) ? 1 : RATIO_RAW;
    localparam int unsigned PW        = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (TICK_HZ == 0 || TICK_HZ > CLK_HZ) begin : g_bad_cfg
        $error("timer_prescaler: TICK_HZ must be nonzero and not exceed CLK_HZ");
    end

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          tick_q;
    logic          wrap_c;

    assign wrap_c = (cnt_q == PW'(RATIO - 1));
    assign cnt_d  = wrap_c ? '0 : cnt_q + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= LOW;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap_c;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable timer: shared prescaler tick feeding independent one-shot/periodic down-counters.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned TICK_HZ     = 1_000,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             start,
    input  logic [CHANNELS-1:0]             stop,
    input  logic [CHANNELS-1:0]             clear,
    input  logic [CHANNELS-1:0]             periodic,
    input  logic [CHANNELS*COUNT_WIDTH-1:0] period,
    output logic                            tick,
    output logic [CHANNELS-1:0]             running,
    output logic [CHANNELS-1:0]             expired,
    output logic [CHANNELS-1:0]             done
);

    localparam int unsigned CW = COUNT_WIDTH;

    logic tick_c;

    timer_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_c)
    );

    assign tick = tick_c;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        ch_state_e     state_q;
        ch_state_e     state_d;
        logic [CW-1:0] count_q;
        logic [CW-1:0] count_d;
        logic          done_q;
        logic          done_d;
        logic          running_q;
        logic          running_d;
        logic          expired_q;
        logic          expired_d;
        logic [CW-1:0] per_c;
        logic          start_c;
        logic          expire_c;

        assign per_c   = period[i*CW +: CW];
        // A start with a zero period behaves as if it were never issued.
        assign start_c = start[i] && (per_c != '0);
        assign expire_c = !clear[i] && !start_c && !stop[i] && tick_c
                          && (state_q == CH_RUN) && (count_q <= CW'(1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= CH_IDLE;
                count_q   <= '0;
                done_q    <= LOW;
                running_q <= LOW;
                expired_q <= LOW;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                done_q    <= done_d;
                running_q <= running_d;
                expired_q <= expired_d;
            end
        end

        // Command priority: clear > start > stop > tick.
        always_comb begin
            state_d = state_q;
            count_d = count_q;
            if (clear[i]) begin
                state_d = CH_IDLE;
                count_d = '0;
            end else if (start_c) begin
                state_d = CH_RUN;
                count_d = per_c;
            end else if (stop[i]) begin
                if (state_q == CH_RUN) begin
                    state_d = CH_IDLE;
                end
            end else if (tick_c && (state_q == CH_RUN)) begin
                if (count_q > CW'(1)) begin
                    count_d = count_q - CW'(1);
                end else if (periodic[i]) begin
                    count_d = per_c;
                    if (per_c == '0) begin
                        state_d = CH_IDLE;
                    end
                end else begin
                    state_d = CH_DONE;
                    count_d = '0;
                end
            end
        end

        always_comb begin
            running_d = (state_d == CH_RUN);
            expired_d = expire_c;
            done_d    = done_q;
            if (clear[i] || start_c) begin
                done_d = LOW;
            end else if (expire_c && !periodic[i]) begin
                done_d = HIGH;
            end
        end

        assign running[i] = running_q;
        assign expired[i] = expired_q;
        assign done[i]    = done_q;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (ratio 10, 4 channels, 8-bit counts).
module tb_multi_timer;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 8;

    logic              clk;
    logic              reset;
    logic [CH-1:0]     start;
    logic [CH-1:0]     stop;
    logic [CH-1:0]     clear;
    logic [CH-1:0]     periodic;
    logic [CH*CW-1:0]  period;
    logic              tick;
    logic [CH-1:0]     running;
    logic [CH-1:0]     expired;
    logic [CH-1:0]     done;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;
    int ch3_act  = 0;

    multi_timer #(
        .CLK_HZ      (100),
        .TICK_HZ     (10),
        .CHANNELS    (CH),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .periodic (periodic),
        .period   (period),
        .tick     (tick),
        .running  (running),
        .expired  (expired),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && (running[3] || expired[3] || done[3])) ch3_act++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed running simulation expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    task automatic wait_exp(input int ch, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (expired[ch]) begin
                at = n;
                break;
            end
        end
    endtask

    initial begin
        int at;
        int e1;
        int e2;
        int e3;
        int e4;
        int e5;
        int pulses;

        reset    = 1'b1;
        start    = '0;
        stop     = '0;
        clear    = '0;
        periodic = '0;
        period   = '0;

        // 1. reset state and prescaler cadence
        repeat (2) @(negedge clk);
        check("rst_tick", 32'(tick), 0);
        check("rst_running", 32'(running), 0);
        check("rst_expired", 32'(expired), 0);
        check("rst_done", 32'(done), 0);
        reset = 1'b0;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            check("tick_cadence", 32'(tick), (n % 10 == 0) ? 1 : 0);
        end
        check("idle_outputs", 32'({running, expired, done}), 0);

        // 2. ch0 one-shot, period 3 (start coincides with a tick, which is ignored)
        period[0*CW +: CW] = 8'd3;
        periodic[0] = 1'b0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("ch0_running_after_start", 32'(running[0]), 1);
        wait_exp(0, 100, at);
        check("ch0_oneshot_expiry_cycle", 32'(at), 61);
        check("ch0_done_set", 32'(done[0]), 1);
        check("ch0_running_cleared", 32'(running[0]), 0);
        step();
        check("ch0_expired_one_cycle", 32'(expired[0]), 0);
        pulses = 0;
        repeat (100) begin
            step();
            if (expired[0]) pulses++;
        end
        check("ch0_no_repeat_pulses", 32'(pulses), 0);
        check("ch0_done_sticky", 32'(done[0]), 1);

        // 3. ch1 periodic, period 2 then 4 mid-count
        period[1*CW +: CW] = 8'd2;
        periodic[1] = 1'b1;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        check("ch1_running_after_start", 32'(running[1]), 1);
        wait_exp(1, 100, e1);
        check("ch1_first_expiry_cycle", 32'(e1), 181);
        wait_exp(1, 100, e2);
        check("ch1_interval_p2", 32'(e2 - e1), 20);
        period[1*CW +: CW] = 8'd4;
        wait_exp(1, 100, e3);
        check("ch1_interval_current_kept", 32'(e3 - e2), 20);
        wait_exp(1, 100, e4);
        check("ch1_interval_p4_a", 32'(e4 - e3), 40);
        wait_exp(1, 100, e5);
        check("ch1_interval_p4_b", 32'(e5 - e4), 40);
        check("ch1_still_running", 32'(running[1]), 1);
        check("ch1_no_done_periodic", 32'(done[1]), 0);
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
        check("ch1_stopped", 32'(running[1]), 0);

        // 4. ch2 command priorities
        period[2*CW +: CW] = 8'd5;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        check("ch2_running", 32'(running[2]), 1);
        clear[2] = 1'b1;
        start[2] = 1'b1;
        step();
        clear[2] = 1'b0;
        start[2] = 1'b0;
        check("ch2_clear_beats_start_run", 32'(running[2]), 0);
        check("ch2_clear_beats_start_done", 32'(done[2]), 0);
        start[2] = 1'b1;
        stop[2]  = 1'b1;
        step();
        start[2] = 1'b0;
        stop[2]  = 1'b0;
        check("ch2_start_beats_stop", 32'(running[2]), 1);
        clear[2] = 1'b1;
        step();
        clear[2] = 1'b0;
        check("ch2_clear_to_idle", 32'(running[2]), 0);
        period[2*CW +: CW] = 8'd0;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        check("ch2_zero_period_ignored", 32'(running[2]), 0);
        pulses = 0;
        repeat (60) begin
            step();
            if (expired[2]) pulses++;
        end
        check("ch2_no_pulses", 32'(pulses), 0);

        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        check("ch0_clear_drops_done", 32'(done[0]), 0);

        // 5. ch0 restart while count is 1
        period[0*CW +: CW] = 8'd3;
        periodic[0] = 1'b0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("ch0_rerun", 32'(running[0]), 1);
        repeat (16) step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_exp(0, 100, at);
        check("ch0_restart_expiry_cycle", 32'(at), 411);
        check("ch0_restart_done", 32'(done[0]), 1);

        // 6. asynchronous reset mid-count
        period[0*CW +: CW] = 8'd5;
        periodic[0] = 1'b0;
        start[0] = 1'b1;
        period[1*CW +: CW] = 8'd2;
        periodic[1] = 1'b1;
        start[1] = 1'b1;
        step();
        start = '0;
        repeat (13) step();
        check("pre_reset_running", 32'(running[1:0]), 3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_running", 32'(running), 0);
        check("async_rst_expired", 32'(expired), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_tick", 32'(tick), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        pulses = 0;
        repeat (40) begin
            step();
            if (expired != '0) pulses++;
        end
        check("no_stale_expiry", 32'(pulses), 0);
        check("no_stale_running", 32'(running), 0);
        period[0*CW +: CW] = 8'd2;
        periodic[0] = 1'b0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_exp(0, 100, at);
        check("post_reset_expiry_cycle", 32'(at), 61);

        check("ch3_untouched", 32'(ch3_act), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
